// File: rtl/ecdsa_vector_sequencer.sv
// Walks a Wycheproof ECDSA vector ROM through one verify core, scoring each verdict
// against the vector's expected result.
//
//   state      | meaning
//   S_IDLE     | waiting for start; done holds the last run's outcome
//   S_FETCH    | rom_en high for one cycle at rom_addr = idx
//   S_WAIT_ROM | rom_data valid; captured into core_vec / exp_reg
//   S_ISSUE    | core_req_valid held until core_req_ready
//   S_WAIT_RSP | waiting for core verdict, timeout down-counter running
//   S_CHECK    | score verdict, advance idx
//   S_DONE     | one-cycle end-of-run state, then IDLE
module ecdsa_vector_sequencer #(
  parameter int          KEY_W       = 521,
  parameter int          HASH_W      = 512,
  parameter int          IDX_W       = 12,
  parameter int          TO_W        = 20,
  parameter int unsigned TIMEOUT_CYC = 20'hFFFFF,
  localparam int         VEC_W       = 4*KEY_W + HASH_W + 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [IDX_W-1:0] num_vectors,
  output logic             rom_en,
  output logic [IDX_W-1:0] rom_addr,
  input  logic [VEC_W-1:0] rom_data,
  output logic             core_req_valid,
  input  logic             core_req_ready,
  output logic [VEC_W-3:0] core_vec,
  input  logic             core_rsp_valid,
  input  logic             core_rsp_ok,
  output logic             busy,
  output logic             done,
  output logic [IDX_W-1:0] pass_cnt,
  output logic [IDX_W-1:0] fail_cnt,
  output logic [IDX_W-1:0] acc_cnt,
  output logic             first_fail_vld,
  output logic [IDX_W-1:0] first_fail_idx,
  output logic             timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT_ROM, S_ISSUE, S_WAIT_RSP, S_CHECK, S_DONE
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] num_reg;
  logic [IDX_W-1:0] idx;
  logic [1:0]       exp_reg;
  logic             rsp_ok;
  logic [TO_W-1:0]  tmr;
  logic [IDX_W:0]   idx_inc;
  logic             last_vec;
  logic             score_fail;

  assign idx_inc  = {1'b0, idx} + (IDX_W+1)'(1);
  assign last_vec = (idx_inc == {1'b0, num_reg});

  // Acceptable vectors (10) never fail; reserved (11) always fails.
  always_comb begin
    score_fail = 1'b0;
    case (exp_reg)
      2'b00, 2'b01: score_fail = (rsp_ok != exp_reg[0]);
      2'b11:        score_fail = 1'b1;
      default:      score_fail = 1'b0;
    endcase
  end

  function automatic logic [IDX_W-1:0] sat_inc(input logic [IDX_W-1:0] v);
    return (&v) ? v : v + IDX_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      rom_en         <= 1'b0;
      rom_addr       <= '0;
      core_req_valid <= 1'b0;
      core_vec       <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass_cnt       <= '0;
      fail_cnt       <= '0;
      acc_cnt        <= '0;
      first_fail_vld <= 1'b0;
      first_fail_idx <= '0;
      timeout_err    <= 1'b0;
      num_reg        <= '0;
      idx            <= '0;
      exp_reg        <= '0;
      rsp_ok         <= 1'b0;
      tmr            <= '0;
    end else begin
      rom_en <= 1'b0;
      if (busy && abort) begin
        state          <= S_IDLE;
        busy           <= 1'b0;
        core_req_valid <= 1'b0;
      end else begin
        case (state)
          S_IDLE, S_DONE: begin
            state <= S_IDLE;
            if (start) begin
              pass_cnt       <= '0;
              fail_cnt       <= '0;
              acc_cnt        <= '0;
              first_fail_vld <= 1'b0;
              first_fail_idx <= '0;
              timeout_err    <= 1'b0;
              num_reg        <= num_vectors;
              idx            <= '0;
              if (num_vectors == '0) begin
                state <= S_DONE;
                done  <= 1'b1;
              end else begin
                state    <= S_FETCH;
                busy     <= 1'b1;
                done     <= 1'b0;
                rom_en   <= 1'b1;
                rom_addr <= '0;
              end
            end
          end
          S_FETCH: state <= S_WAIT_ROM;
          S_WAIT_ROM: begin
            core_vec       <= rom_data[VEC_W-1:2];
            exp_reg        <= rom_data[1:0];
            core_req_valid <= 1'b1;
            state          <= S_ISSUE;
          end
          S_ISSUE: begin
            if (core_req_ready) begin
              core_req_valid <= 1'b0;
              tmr            <= TO_W'(TIMEOUT_CYC);
              state          <= S_WAIT_RSP;
            end
          end
          S_WAIT_RSP: begin
            // A verdict on the terminal-count cycle still counts as a response.
            if (core_rsp_valid) begin
              rsp_ok <= core_rsp_ok;
              state  <= S_CHECK;
            end else if (tmr == '0) begin
              fail_cnt    <= sat_inc(fail_cnt);
              timeout_err <= 1'b1;
              if (!first_fail_vld) begin
                first_fail_vld <= 1'b1;
                first_fail_idx <= idx;
              end
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              tmr <= tmr - TO_W'(1);
            end
          end
          S_CHECK: begin
            if (exp_reg == 2'b10) begin
              acc_cnt <= sat_inc(acc_cnt);
            end else if (score_fail) begin
              fail_cnt <= sat_inc(fail_cnt);
              if (!first_fail_vld) begin
                first_fail_vld <= 1'b1;
                first_fail_idx <= idx;
              end
            end else begin
              pass_cnt <= sat_inc(pass_cnt);
            end
            idx <= idx_inc[IDX_W-1:0];
            if (last_vec) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state    <= S_FETCH;
              rom_en   <= 1'b1;
              rom_addr <= idx_inc[IDX_W-1:0];
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ecdsa_vector_sequencer.sv
// Bench for ecdsa_vector_sequencer: behavioural ROM and verify core, scoring checked
// against a per-run tally model built from the vector table.
module tb_ecdsa_vector_sequencer;
  localparam int KW = 8, HW = 8, IW = 6, TW = 8, TO = 8;
  localparam int VW = 4*KW + HW + 2;

  logic clk = 1'b0;
  logic rst, start, abort;
  logic [IW-1:0] num_vectors;
  logic rom_en;
  logic [IW-1:0] rom_addr;
  logic [VW-1:0] rom_data;
  logic core_req_valid, core_req_ready;
  logic [VW-3:0] core_vec;
  logic core_rsp_valid, core_rsp_ok;
  logic busy, done;
  logic [IW-1:0] pass_cnt, fail_cnt, acc_cnt, first_fail_idx;
  logic first_fail_vld, timeout_err;

  ecdsa_vector_sequencer #(.KEY_W(KW), .HASH_W(HW), .IDX_W(IW), .TO_W(TW), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .num_vectors(num_vectors),
    .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
    .core_req_valid(core_req_valid), .core_req_ready(core_req_ready), .core_vec(core_vec),
    .core_rsp_valid(core_rsp_valid), .core_rsp_ok(core_rsp_ok),
    .busy(busy), .done(done), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .acc_cnt(acc_cnt),
    .first_fail_vld(first_fail_vld), .first_fail_idx(first_fail_idx), .timeout_err(timeout_err));

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;

  // Vector table: ROM contents plus per-vector core behaviour.
  logic [VW-1:0] rom_mem [64];
  int  rdy_dly [64];
  int  rsp_dly [64];   // cycles after handshake; 0 = never answer
  bit  ok_tab  [64];

  int hs_total = 0, hs_base = 0, rom_cnt = 0, rom_base = 0;
  int stab_err = 0, stall_cyc = 0;
  logic [VW-3:0] hs_vec [256];
  bit prev_wait = 1'b0;
  logic [VW-3:0] prev_vec;

  always @(posedge clk) begin
    if (rom_en) rom_data <= rom_mem[rom_addr];
    rom_cnt <= rom_cnt + int'(rom_en);
    if (core_req_valid && core_req_ready) begin
      hs_vec[hs_total % 256] <= core_vec;
      hs_total <= hs_total + 1;
    end
    if (prev_wait && (!core_req_valid || core_vec !== prev_vec)) stab_err <= stab_err + 1;
    prev_wait <= core_req_valid && !core_req_ready && !abort && !rst;
    prev_vec  <= core_vec;
    if (core_req_valid && !core_req_ready) stall_cyc <= stall_cyc + 1;
  end

  bit core_en = 1'b0;
  int hs_seen = 0, rdy_cnt = 0, rsp_cnt = -1, cur = 0;

  always @(negedge clk) begin
    core_rsp_valid = 1'b0;
    if (!core_en) begin
      core_req_ready = 1'b0; rdy_cnt = 0; rsp_cnt = -1; hs_seen = hs_total;
    end else begin
      if (hs_seen != hs_total) begin
        hs_seen = hs_total; core_req_ready = 1'b0; rdy_cnt = 0; rsp_cnt = 0;
        cur = (hs_total - hs_base - 1) & 63;
      end
      if (rsp_cnt >= 0) begin
        rsp_cnt++;
        if (rsp_cnt == rsp_dly[cur]) begin
          core_rsp_valid = 1'b1; core_rsp_ok = ok_tab[cur]; rsp_cnt = -1;
        end
      end
      if (core_req_valid && !core_req_ready) begin
        if (rdy_cnt >= rdy_dly[(hs_total - hs_base) & 63]) core_req_ready = 1'b1;
        else rdy_cnt++;
      end
    end
  end

  // Reference model: walks the table in order, scoring by expect code.
  int m_pass, m_fail, m_acc, m_ffv, m_ffi, m_to, m_cyc, m_hs;
  function automatic void model_run(input int n);
    m_pass = 0; m_fail = 0; m_acc = 0; m_ffv = 0; m_ffi = 0; m_to = 0; m_cyc = 1; m_hs = 0;
    for (int i = 0; i < n; i++) begin
      logic [1:0] e;
      bit bad;
      e = rom_mem[i][1:0];
      m_hs++;
      if (rsp_dly[i] == 0 || rsp_dly[i] > TO + 1) begin
        m_fail++; m_to = 1; m_cyc += rdy_dly[i] + TO + 4;
        if (m_ffv == 0) begin m_ffv = 1; m_ffi = i; end
        break;
      end
      m_cyc += 4 + rdy_dly[i] + rsp_dly[i];
      if (e == 2'b10) m_acc++;
      else begin
        bad = (e == 2'b11) || (e == 2'b01 && !ok_tab[i]) || (e == 2'b00 && ok_tab[i]);
        if (bad) begin
          m_fail++;
          if (m_ffv == 0) begin m_ffv = 1; m_ffi = i; end
        end else m_pass++;
      end
    end
  endfunction

  task automatic set_vec(input int i, input logic [1:0] e, input bit ok);
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    rom_mem[i] = {r[VW-3:0], e};
    ok_tab[i] = ok; rdy_dly[i] = 0; rsp_dly[i] = 1;
  endtask

  task automatic start_run(input int n);
    core_en = 1'b0;
    @(posedge clk); @(negedge clk); #1;
    hs_base = hs_total; rom_base = rom_cnt; core_en = 1'b1;
    num_vectors = IW'(n); start = 1'b1;
  endtask

  task automatic do_run(input int n, input int poke, output int cyc, output bit to);
    start_run(n);
    cyc = 0; to = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      @(posedge clk); cyc++;
      @(negedge clk); start = 1'b0;
      if (done) begin to = 1'b0; break; end
      if (cyc == poke) begin start = 1'b1; num_vectors = IW'(1); end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({rom_en, core_req_valid, busy, done, first_fail_vld, timeout_err} !== 6'b0) begin
      n_bad++; $display("FAIL reset_ctrl got %b want 000000",
        {rom_en, core_req_valid, busy, done, first_fail_vld, timeout_err});
    end
    n_cmp++;
    if ({rom_addr, core_vec, pass_cnt, fail_cnt, acc_cnt, first_fail_idx} !== '0) begin
      n_bad++; $display("FAIL reset_data got addr=%0d vec=%h p=%0d f=%0d a=%0d ffi=%0d want all 0",
        rom_addr, core_vec, pass_cnt, fail_cnt, acc_cnt, first_fail_idx);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic_scoring();
    int cyc; bit to;
    set_vec(0, 2'b01, 1'b1); set_vec(1, 2'b00, 1'b0); set_vec(2, 2'b10, 1'b0);
    do_run(3, -1, cyc, to);
    n_cmp++;
    if (to || {pass_cnt, acc_cnt, fail_cnt} !== {IW'(2), IW'(1), IW'(0)}) begin
      n_bad++; $display("FAIL basic_tally got p=%0d a=%0d f=%0d timeout=%0d want p=2 a=1 f=0",
        pass_cnt, acc_cnt, fail_cnt, to);
    end
    n_cmp++;
    if (cyc != 16 || busy !== 1'b0) begin
      n_bad++; $display("FAIL basic_latency got cyc=%0d busy=%b want cyc=16 busy=0", cyc, busy);
    end
  endtask

  task automatic test_first_fail();
    int cyc; bit to;
    set_vec(0, 2'b01, 1'b1); set_vec(1, 2'b01, 1'b0); set_vec(2, 2'b00, 1'b1);
    do_run(3, -1, cyc, to);
    n_cmp++;
    if (to || fail_cnt !== IW'(2) || pass_cnt !== IW'(1) || first_fail_vld !== 1'b1 ||
        first_fail_idx !== IW'(1)) begin
      n_bad++; $display("FAIL first_fail got f=%0d p=%0d vld=%b idx=%0d want f=2 p=1 vld=1 idx=1",
        fail_cnt, pass_cnt, first_fail_vld, first_fail_idx);
    end
  endtask

  task automatic test_stall();
    int cyc, s0, st0; bit to;
    set_vec(0, 2'b01, 1'b1); rdy_dly[0] = 10;
    s0 = stab_err; st0 = stall_cyc;
    do_run(1, -1, cyc, to);
    n_cmp++;
    if (to || stab_err != s0 || stall_cyc - st0 != 10) begin
      n_bad++; $display("FAIL stall_hold got unstable=%0d stalled=%0d want unstable=0 stalled=10",
        stab_err - s0, stall_cyc - st0);
    end
    n_cmp++;
    if (hs_total - hs_base != 1 || hs_vec[hs_base % 256] !== rom_mem[0][VW-1:2] || cyc != 16) begin
      n_bad++; $display("FAIL stall_handshake got hs=%0d vec=%h cyc=%0d want hs=1 vec=%h cyc=16",
        hs_total - hs_base, hs_vec[hs_base % 256], cyc, rom_mem[0][VW-1:2]);
    end
  endtask

  task automatic test_timeout();
    int cyc; bit to;
    set_vec(0, 2'b01, 1'b1); set_vec(1, 2'b01, 1'b1); rsp_dly[0] = 0;
    do_run(2, -1, cyc, to);
    n_cmp++;
    if (to || {timeout_err, done, busy, first_fail_vld} !== 4'b1101 || fail_cnt !== IW'(1) ||
        first_fail_idx !== IW'(0) || cyc != TO + 5 || hs_total - hs_base != 1) begin
      n_bad++; $display("FAIL timeout got to_err=%b done=%b busy=%b f=%0d cyc=%0d hs=%0d want 1 1 0 f=1 cyc=%0d hs=1",
        timeout_err, done, busy, fail_cnt, cyc, hs_total - hs_base, TO + 5);
    end
    rsp_dly[0] = TO + 1;
    do_run(1, -1, cyc, to);
    n_cmp++;
    if (to || timeout_err !== 1'b0 || pass_cnt !== IW'(1) || fail_cnt !== IW'(0) || cyc != TO + 6) begin
      n_bad++; $display("FAIL timeout_edge_rsp got to_err=%b p=%0d f=%0d cyc=%0d want 0 p=1 f=0 cyc=%0d",
        timeout_err, pass_cnt, fail_cnt, cyc, TO + 6);
    end
    rsp_dly[0] = TO + 2;
    do_run(1, -1, cyc, to);
    n_cmp++;
    if (to || timeout_err !== 1'b1 || pass_cnt !== IW'(0) || fail_cnt !== IW'(1) || cyc != TO + 5) begin
      n_bad++; $display("FAIL timeout_late_rsp got to_err=%b p=%0d f=%0d cyc=%0d want 1 p=0 f=1 cyc=%0d",
        timeout_err, pass_cnt, fail_cnt, cyc, TO + 5);
    end
  endtask

  task automatic test_zero_vectors();
    int cyc; bit to;
    do_run(0, -1, cyc, to);
    n_cmp++;
    if (to || cyc != 1 || done !== 1'b1 || busy !== 1'b0 || rom_cnt != rom_base ||
        {pass_cnt, fail_cnt, acc_cnt, first_fail_vld, timeout_err} !== '0) begin
      n_bad++; $display("FAIL zero_vectors got cyc=%0d done=%b busy=%b roms=%0d p=%0d f=%0d a=%0d want cyc=1 1 0 roms=0 counts 0",
        cyc, done, busy, rom_cnt - rom_base, pass_cnt, fail_cnt, acc_cnt);
    end
  endtask

  task automatic test_start_busy();
    int cyc; bit to;
    for (int i = 0; i < 5; i++) set_vec(i, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    model_run(5);
    do_run(5, 8, cyc, to);
    n_cmp++;
    if (to || cyc != m_cyc || pass_cnt !== IW'(m_pass) || fail_cnt !== IW'(m_fail) ||
        acc_cnt !== IW'(m_acc) || hs_total - hs_base != 5) begin
      n_bad++; $display("FAIL start_busy got cyc=%0d p=%0d f=%0d a=%0d hs=%0d want cyc=%0d p=%0d f=%0d a=%0d hs=5",
        cyc, pass_cnt, fail_cnt, acc_cnt, hs_total - hs_base, m_cyc, m_pass, m_fail, m_acc);
    end
  endtask

  task automatic test_abort();
    bit reached = 1'b0;
    set_vec(0, 2'b01, 1'b1); set_vec(1, 2'b00, 1'b0); set_vec(2, 2'b01, 1'b1);
    rsp_dly[1] = 6;
    start_run(3);
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); @(negedge clk); start = 1'b0;
      if (hs_total - hs_base >= 2) begin reached = 1'b1; break; end
    end
    n_cmp++;
    if (!reached) begin
      n_bad++; $display("FAIL abort_reach got hs=%0d want 2 within 100 cycles", hs_total - hs_base);
    end
    abort = 1'b1;
    @(posedge clk); @(negedge clk); abort = 1'b0;
    n_cmp++;
    if ({busy, done, core_req_valid, rom_en} !== 4'b0 || pass_cnt !== IW'(1) || fail_cnt !== IW'(0)) begin
      n_bad++; $display("FAIL abort_next got busy=%b done=%b valid=%b rom_en=%b p=%0d f=%0d want 0 0 0 0 p=1 f=0",
        busy, done, core_req_valid, rom_en, pass_cnt, fail_cnt);
    end
    repeat (10) @(negedge clk);
    n_cmp++;
    if ({busy, done} !== 2'b0 || pass_cnt !== IW'(1) || fail_cnt !== IW'(0) || acc_cnt !== IW'(0) ||
        rom_cnt - rom_base != 2) begin
      n_bad++; $display("FAIL abort_idle got busy=%b done=%b p=%0d f=%0d a=%0d roms=%0d want 0 0 p=1 f=0 a=0 roms=2",
        busy, done, pass_cnt, fail_cnt, acc_cnt, rom_cnt - rom_base);
    end
  endtask

  task automatic test_rst_midrun();
    for (int i = 0; i < 4; i++) set_vec(i, 2'b01, 1'b1);
    start_run(4);
    repeat (8) begin @(posedge clk); @(negedge clk); start = 1'b0; end
    n_cmp++;
    if (busy !== 1'b1 || pass_cnt !== IW'(1)) begin
      n_bad++; $display("FAIL rst_pre got busy=%b p=%0d want busy=1 p=1", busy, pass_cnt);
    end
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    n_cmp++;
    if ({rom_en, core_req_valid, busy, done, first_fail_vld, timeout_err, rom_addr, core_vec,
         pass_cnt, fail_cnt, acc_cnt, first_fail_idx} !== '0) begin
      n_bad++; $display("FAIL rst_midrun got busy=%b done=%b valid=%b vec=%h p=%0d addr=%0d want all 0",
        busy, done, core_req_valid, core_vec, pass_cnt, rom_addr);
    end
    rst = 1'b0;
  endtask

  task automatic test_random_runs();
    int cyc, n, r; bit to;
    for (int run = 0; run < 10; run++) begin
      n = $urandom_range(1, 12);
      for (int i = 0; i < n; i++) begin
        set_vec(i, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        rdy_dly[i] = $urandom_range(0, 3);
        r = $urandom_range(0, 19);
        rsp_dly[i] = (r == 0) ? 0 : (r == 1) ? TO + 1 : (r == 2) ? TO + 2 : $urandom_range(1, 4);
      end
      model_run(n);
      do_run(n, -1, cyc, to);
      n_cmp++;
      if (to || pass_cnt !== IW'(m_pass) || fail_cnt !== IW'(m_fail) || acc_cnt !== IW'(m_acc) ||
          first_fail_vld !== 1'(m_ffv) || first_fail_idx !== IW'(m_ffi) || timeout_err !== 1'(m_to)) begin
        n_bad++; $display("FAIL rand%0d_tally got p=%0d f=%0d a=%0d ffv=%b ffi=%0d to=%b want p=%0d f=%0d a=%0d ffv=%0d ffi=%0d to=%0d",
          run, pass_cnt, fail_cnt, acc_cnt, first_fail_vld, first_fail_idx, timeout_err,
          m_pass, m_fail, m_acc, m_ffv, m_ffi, m_to);
      end
      n_cmp++;
      if (cyc != m_cyc || hs_total - hs_base != m_hs) begin
        n_bad++; $display("FAIL rand%0d_timing got cyc=%0d hs=%0d want cyc=%0d hs=%0d",
          run, cyc, hs_total - hs_base, m_cyc, m_hs);
      end
      for (int i = 0; i < m_hs; i++) begin
        n_cmp++;
        if (hs_vec[(hs_base + i) % 256] !== rom_mem[i][VW-1:2]) begin
          n_bad++; $display("FAIL rand%0d_vec%0d got %h want %h",
            run, i, hs_vec[(hs_base + i) % 256], rom_mem[i][VW-1:2]);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; num_vectors = '0;
    core_req_ready = 1'b0; core_rsp_valid = 1'b0; core_rsp_ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      rom_mem[i] = '0; rdy_dly[i] = 0; rsp_dly[i] = 1; ok_tab[i] = 1'b0;
    end
    test_reset();
    test_basic_scoring();
    test_first_fail();
    test_stall();
    test_timeout();
    test_zero_vectors();
    test_start_busy();
    test_abort();
    test_rst_midrun();
    test_random_runs();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
